// File: rtl/regfile_wb_pkg.sv
// Shared widths and the buffered write-request payload for the register-file writeback path.
package regfile_wb_pkg;
  localparam int unsigned LOG_REG_CNT           = 2;
  localparam int unsigned LOG_SUPERSCALAR_WIDTH = 4;
  localparam int unsigned REG_WIDTH             = 288;
  localparam int unsigned ADDR_W                = LOG_REG_CNT + LOG_SUPERSCALAR_WIDTH;
  localparam int unsigned NREGS                 = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [REG_WIDTH-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO; exposes the two oldest entries and per-slot occupancy for hazard tracking.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  wb_req_t                         push_req,
  input  logic [1:0]                      pop_cnt,
  output logic                            full_c,
  output logic                            empty_c,
  output logic                            two_plus_c,
  output wb_req_t                         head0_c,
  output wb_req_t                         head1_c,
  output logic [DEPTH-1:0]                slot_vld_c,
  output logic [DEPTH-1:0][ADDR_W-1:0]    slot_addr_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t                      mem [DEPTH];
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0][PTR_W-1:0]  slot_off_c;
  logic                         do_push;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign two_plus_c = (count >= CNT_W'(2));
  assign do_push    = push && !full_c;
  assign head0_c    = mem[rd_ptr];
  assign head1_c    = mem[rd_ptr + PTR_W'(1)];

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    slot_off_c  = '0;
    slot_vld_c  = '0;
    slot_addr_c = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      slot_off_c[j]  = PTR_W'(j) - rd_ptr;
      slot_vld_c[j]  = (CNT_W'(slot_off_c[j]) < count);
      slot_addr_c[j] = mem[j].addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      count  <= count + CNT_W'(do_push) - CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end
endmodule

// File: rtl/regfile_writeback.sv
// Round-robin writeback initiator: buffers per-source results and drives register-file write ports c and d.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int unsigned N_SRC      = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       freeze,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*ADDR_W-1:0]    src_addr,
  input  logic [N_SRC*REG_WIDTH-1:0] src_data,
  output logic                       port_c_we,
  output logic [ADDR_W-1:0]          port_c_write_addr,
  output logic [REG_WIDTH-1:0]       port_c_in,
  output logic                       port_d_we,
  output logic [ADDR_W-1:0]          port_d_write_addr,
  output logic [REG_WIDTH-1:0]       port_d_in,
  output logic [NREGS-1:0]           pending,
  output logic                       idle
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]                             full_c;
  logic [N_SRC-1:0]                             empty_c;
  logic [N_SRC-1:0]                             two_plus_c;
  wb_req_t                                      head0_c   [N_SRC];
  wb_req_t                                      head1_c   [N_SRC];
  wb_req_t                                      push_req_c[N_SRC];
  logic [N_SRC-1:0][FIFO_DEPTH-1:0]             slot_vld_c;
  logic [N_SRC-1:0][FIFO_DEPTH-1:0][ADDR_W-1:0] slot_addr_c;
  logic [N_SRC-1:0][1:0]                        pop_cnt_c;
  logic [SRC_W-1:0]                             rr_ptr;
  logic [SRC_W-1:0]                             rr_ptr_nxt_c;
  logic [SRC_W-1:0]                             idx_c;
  logic                                         grant_c_c;
  logic                                         grant_d_c;
  wb_req_t                                      req_c_c;
  wb_req_t                                      req_d_c;

  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int unsigned step);
    int unsigned sum;
    sum = 32'(base) + step;
    if (sum >= N_SRC) sum = sum - N_SRC;
    return SRC_W'(sum);
  endfunction

  assign src_ready = ~full_c & {N_SRC{reset}};

  for (genvar i = 0; i < int'(N_SRC); i++) begin : g_src
    assign push_req_c[i] = {src_addr[i*ADDR_W +: ADDR_W], src_data[i*REG_WIDTH +: REG_WIDTH]};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (src_valid[i] && src_ready[i]),
      .push_req    (push_req_c[i]),
      .pop_cnt     (freeze ? 2'd0 : pop_cnt_c[i]),
      .full_c      (full_c[i]),
      .empty_c     (empty_c[i]),
      .two_plus_c  (two_plus_c[i]),
      .head0_c     (head0_c[i]),
      .head1_c     (head1_c[i]),
      .slot_vld_c  (slot_vld_c[i]),
      .slot_addr_c (slot_addr_c[i])
    );
  end

  // Scan heads from rr_ptr; port d skips any head aliasing the port-c address.
  always_comb begin
    grant_c_c    = 1'b0;
    grant_d_c    = 1'b0;
    req_c_c      = '0;
    req_d_c      = '0;
    pop_cnt_c    = '0;
    rr_ptr_nxt_c = rr_ptr;
    idx_c        = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx_c = wrap_idx(rr_ptr, k);
      if (!empty_c[idx_c]) begin
        if (!grant_c_c) begin
          grant_c_c        = 1'b1;
          req_c_c          = head0_c[idx_c];
          pop_cnt_c[idx_c] = 2'd1;
          rr_ptr_nxt_c     = wrap_idx(idx_c, 1);
        end else if (!grant_d_c && (head0_c[idx_c].addr != req_c_c.addr)) begin
          grant_d_c        = 1'b1;
          req_d_c          = head0_c[idx_c];
          pop_cnt_c[idx_c] = 2'd1;
          rr_ptr_nxt_c     = wrap_idx(idx_c, 1);
        end
      end
    end
    if (N_SRC == 1) begin
      if (grant_c_c && two_plus_c[0] && (head1_c[0].addr != req_c_c.addr)) begin
        grant_d_c    = 1'b1;
        req_d_c      = head1_c[0];
        pop_cnt_c[0] = 2'd2;
      end
    end
  end

  // Presented writes hold under freeze and commit at the first unfrozen edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_c_we         <= 1'b0;
      port_c_write_addr <= '0;
      port_c_in         <= '0;
      port_d_we         <= 1'b0;
      port_d_write_addr <= '0;
      port_d_in         <= '0;
      rr_ptr            <= '0;
    end else if (!freeze) begin
      port_c_we <= grant_c_c;
      port_d_we <= grant_d_c;
      if (grant_c_c) begin
        port_c_write_addr <= req_c_c.addr;
        port_c_in         <= req_c_c.data;
      end
      if (grant_d_c) begin
        port_d_write_addr <= req_d_c.addr;
        port_d_in         <= req_d_c.data;
      end
      rr_ptr <= rr_ptr_nxt_c;
    end
  end

  always_comb begin
    pending = '0;
    for (int s = 0; s < int'(N_SRC); s++) begin
      for (int j = 0; j < int'(FIFO_DEPTH); j++) begin
        if (slot_vld_c[s][j]) pending[slot_addr_c[s][j]] = 1'b1;
      end
    end
    if (port_c_we) pending[port_c_write_addr] = 1'b1;
    if (port_d_we) pending[port_d_write_addr] = 1'b1;
  end

  assign idle = (&empty_c) && !port_c_we && !port_d_we;
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side initiator for the 2-write-port register file.
- Collects writeback results from N_SRC functional units through valid/ready handshakes and buffers each in a small per-source FIFO.
- Issues up to two writes per cycle onto register-file write ports c and d, and honours the global freeze.
- Exports a per-register pending mask so the issue stage can stall on read-after-write hazards.

Parameters:
- LOG_REG_CNT, 2, log2 registers per thread.
- LOG_SUPERSCALAR_WIDTH, 4, log2 thread count.
- REG_WIDTH, 288, register data width (4x4 matrix of 18-bit elements).
- N_SRC, 3, number of writeback sources.
- FIFO_DEPTH, 2, entries per source FIFO (power of 2, at least 2).
- Derived: ADDR_W = LOG_REG_CNT+LOG_SUPERSCALAR_WIDTH; NREGS = 1<<ADDR_W.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- freeze  in  1  global pipeline freeze, same signal the register file sees.
- src_valid  in  N_SRC  per-source write request valid.
- src_ready  out  N_SRC  per-source FIFO can accept.
- src_addr  in  N_SRC*ADDR_W  per-source destination {thread,reg}; source i occupies slice i.
- src_data  in  N_SRC*REG_WIDTH  per-source write data.
- port_c_we  out  1  write enable, port c.
- port_c_write_addr  out  ADDR_W  write address, port c.
- port_c_in  out  REG_WIDTH  write data, port c.
- port_d_we, port_d_write_addr, port_d_in  out  1/ADDR_W/REG_WIDTH  same signals for port d.
- pending  out  NREGS  bit a=1 while a write to address a is buffered or presented.
- idle  out  1  all FIFOs empty and both we low.

Behaviour:
- Reset low, asynchronous:
  - FIFOs emptied, rr_ptr=0.
  - All port_* outputs 0, pending=0, idle=1.
  - src_ready forced 0 while reset is low.
- src_ready[i] = FIFO i not full. Independent of freeze. No accept-while-full even when a pop happens the same cycle.
- Accept on src_valid&src_ready at the edge. Data and address must be stable while valid&&!ready.
- Grant, evaluated combinationally each cycle, committed only when freeze=0:
  - Scan non-empty FIFO heads in order rr_ptr, rr_ptr+1, ... (mod N_SRC).
  - First candidate goes to port c; next candidate goes to port d.
  - A candidate whose address equals the port-c candidate's address is skipped this cycle. This prevents the same-address double write.
  - Granted heads pop. Output registers load {we=1, addr, data}; ungranted ports load we=0 (addr/data may hold).
  - rr_ptr moves to (index of last granted source + 1) mod N_SRC. It is unchanged if nothing is granted.
- Freeze=1:
  - Output registers, rr_ptr and FIFO heads hold; no pops.
  - FIFO pushes continue.
  - The held write commits in the register file at the first unfrozen edge, the same edge at which the next grant loads. No loss, no duplicate.
- Latency: handshake in cycle t, no contention, no freeze → port_c_we=1 in cycle t+2, for exactly one cycle.
- Ordering:
  - Per-source FIFO order is preserved.
  - Cross-source writes to the same address have no order guarantee. Producers use pending to avoid issuing such pairs.
- pending is combinational:
  - OR of decoded addresses of all valid FIFO entries and of presented writes (we=1).
  - Includes a same-cycle push only after the edge.
  - Clears in the cycle after the committing unfrozen edge.
- Boundaries:
  - All FIFOs full and freeze: src_ready=0 everywhere; state holds.
  - N_SRC=1: at most port c is used, except that the second FIFO entry may go to port d when its address differs from the head's. That is the only intra-source dual grant; the older entry always takes port c.

Decomposition:
- Package regfile_wb_pkg holds ADDR_W and NREGS as constants and typedef wb_req_t {logic [ADDR_W-1:0] addr; logic [REG_WIDTH-1:0] data;}.
- Sub-module wb_fifo: parameterised depth, push/pop, full/empty, two head views (entry 0 and entry 1), plus a per-entry valid vector for pending.
- Top level holds the arbiter, output registers and pending decode.

Test Plan:
- Single write: src0 addr 5, data 0xABC accepted in cycle t → cycle t+2 port_c_we=1, addr 5, data 0xABC, port_d_we=0. pending[5]=1 in cycles t+1..t+2 and 0 in t+3. idle returns to 1.
- Three-way contention, rr_ptr=0: sources 0/1/2 write addr 1/2/3 in cycle t:
  - t+2: c=addr 1, d=addr 2.
  - t+3: c=addr 3, d we=0.
  - rr_ptr ends at 0.
- Same-address conflict: src0 and src1 both addr 7, data A/B → t+2 c=7/A, d we=0; t+3 c=7/B.
- Freeze for 3 cycles while c holds addr 4 and src2 keeps pushing:
  - Outputs constant, no pops.
  - src_ready[2]=0 after 2 accepts.
  - After release every write appears exactly once, in FIFO order.
- Reset low mid-traffic with full FIFOs → immediately we=0, pending=0, src_ready=0. After release, idle=1 and no stale writes are issued.
- Fairness: src0 and src2 continuously valid with distinct addresses → both drain at one write per cycle each. Neither waits more than 1 cycle once its head is valid.
